debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 72 +++++++
 rtl/debounce_bank.sv | 45 ++++
 3 files changed

// File: rtl/debounce_bank_pkg.sv
// Shared types for the debounce bank: edge classification of a channel's state toggle.
// Pure declarations; no state, no latency, no backpressure.
package debounce_bank_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_t;

  // A toggle from 0 is a rise, from 1 a fall.
  function automatic edge_t edge_kind(input logic toggle, input logic old_state);
    edge_t kind;
    kind = EDGE_NONE;
    if (toggle) begin
      kind = old_state ? EDGE_FALL : EDGE_RISE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser chain, stability counter, registered state and edge pulses.
// Latency SYNC_STAGES + 2^WIDTH edges from pin to state; free-running, no backpressure.
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int   WIDTH       = 2,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic state,
  output logic rise,
  output logic fall,
  output logic toggle
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       count_d;
  logic                   state_q;
  logic                   state_d;
  logic [WIDTH:0]         bumped;
  logic                   differ;
  edge_t                  kind;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{INIT}};
    end else begin
      sync_q[0] <= pin;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Counting through {state,count} makes the state flip exactly on counter carry-out.
  always_comb begin
    differ  = (sync != state_q);
    bumped  = {state_q, count_q} + {{WIDTH{1'b0}}, 1'b1};
    state_d = state_q;
    count_d = '0;
    if (differ) begin
      state_d = bumped[WIDTH];
      count_d = bumped[WIDTH-1:0];
    end
    toggle = differ && (&count_q);
    kind   = edge_kind(toggle, state_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      count_q <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rise    <= (kind == EDGE_RISE);
      fall    <= (kind == EDGE_FALL);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of CHANNELS independent debouncers with per-channel edge pulses and a combined change flag.
// Latency SYNC_STAGES + 2^WIDTH edges pin to state, pulses aligned with state; no backpressure.
module debounce_bank #(
  parameter int                  CHANNELS    = 4,
  parameter int                  WIDTH       = 2,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] INIT_VALUE  = '1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pins,
  output logic [CHANNELS-1:0] state,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  logic [CHANNELS-1:0] toggle;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT        (INIT_VALUE[i])
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .pin    (pins[i]),
      .state  (state[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .toggle (toggle[i])
    );
  end

  // Registered from the same toggles that load rise/fall, so it lands in their cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      changed <= 1'b0;
    end else begin
      changed <= |toggle;
    end
  end

endmodule
